// File: rtl/text_console_writer_pkg.sv
// Shared constants and types for the text console writer: grid geometry,
// VRAM address width, control codes, fill attribute and CGA colour indices.
package text_console_writer_pkg;

  // Text grid geometry for a 480x272 panel with 8x8 cells.
  localparam int COLS  = 60;
  localparam int ROWS  = 34;
  localparam int CELLS = COLS * ROWS;

  // VRAM address width; CELLS must fit in 2**AW words.
  localparam int AW = 11;

  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
  localparam logic [5:0]    COL_MAX   = 6'(COLS - 1);
  localparam logic [5:0]    ROW_MAX   = 6'(ROWS - 1);

  // Clear fill: light grey space on black.
  localparam logic [7:0] CLR_ATTR = 8'h07;
  localparam logic [7:0] CLR_CHAR = 8'h20;

  // Control codes interpreted by the writer.
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  // CGA colour indices for building {bg, fg} attributes.
  localparam logic [3:0] CGA_BLACK      = 4'h0;
  localparam logic [3:0] CGA_BLUE       = 4'h1;
  localparam logic [3:0] CGA_GREEN      = 4'h2;
  localparam logic [3:0] CGA_CYAN       = 4'h3;
  localparam logic [3:0] CGA_RED        = 4'h4;
  localparam logic [3:0] CGA_MAGENTA    = 4'h5;
  localparam logic [3:0] CGA_BROWN      = 4'h6;
  localparam logic [3:0] CGA_LIGHT_GREY = 4'h7;
  localparam logic [3:0] CGA_YELLOW     = 4'hE;
  localparam logic [3:0] CGA_WHITE      = 4'hF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Cursor update requested by the control FSM for the current edge.
  typedef enum logic [2:0] {
    CUR_NONE = 3'd0,
    CUR_ADV  = 3'd1,
    CUR_LF   = 3'd2,
    CUR_CR   = 3'd3,
    CUR_BS   = 3'd4,
    CUR_HOME = 3'd5
  } cursor_cmd_t;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= 8'h20) && (code <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream input and VRAM write port of the text console writer.
//
// Handshake: a character transfers on a rising clk edge where ch_valid_i
// and ch_ready_o are both high. ch_data_i/ch_attr_i are sampled only on
// that edge and ignored otherwise. The producer may hold ch_valid_i high
// while ch_ready_o is low; ch_ready_o does not depend on ch_valid_i.
// The VRAM side has no back-pressure: vram_we_o high for one cycle means
// one word {attr, char} is written at vram_addr_o.
interface text_console_writer_if
  import text_console_writer_pkg::*;
();
  logic          ch_valid_i;
  logic          ch_ready_o;
  logic [7:0]    ch_data_i;
  logic [7:0]    ch_attr_i;
  logic          vram_we_o;
  logic [AW-1:0] vram_addr_o;
  logic [15:0]   vram_data_o;

  modport master (
    output ch_valid_i, ch_data_i, ch_attr_i,
    input  ch_ready_o, vram_we_o, vram_addr_o, vram_data_o
  );

  modport slave (
    input  ch_valid_i, ch_data_i, ch_attr_i,
    output ch_ready_o, vram_we_o, vram_addr_o, vram_data_o
  );
endinterface

// File: rtl/text_console_writer_cursor.sv
// Cursor tracker: (col,row) plus a linear cell address kept in step
// incrementally so addr == row*COLS + col without a multiplier.
module text_console_writer_cursor
  import text_console_writer_pkg::*;
(
  input  logic          clk_i,
  input  logic          rstn_i,
  input  cursor_cmd_t   cmd,
  output logic [5:0]    col,
  output logic [5:0]    row,
  output logic [AW-1:0] addr
);

  logic [5:0]    col_next;
  logic [5:0]    row_next;
  logic [AW-1:0] addr_next;

  // Next cursor position and matching linear address for each command.
  always_comb begin
    col_next  = col;
    row_next  = row;
    addr_next = addr;
    case (cmd)
      CUR_ADV: begin
        if (col == COL_MAX) begin
          col_next = '0;
          row_next = (row == ROW_MAX) ? '0 : row + 6'd1;
        end else begin
          col_next = col + 6'd1;
        end
        addr_next = (addr == LAST_ADDR) ? '0 : addr + AW'(1);
      end
      CUR_LF: begin
        col_next = '0;
        if (row == ROW_MAX) begin
          // Bottom row wraps to the top; no scrolling.
          row_next  = '0;
          addr_next = '0;
        end else begin
          row_next  = row + 6'd1;
          addr_next = addr + AW'(COLS) - AW'(col);
        end
      end
      CUR_CR: begin
        col_next  = '0;
        addr_next = addr - AW'(col);
      end
      CUR_BS: begin
        // Backspace moves left only; it never erases and stops at col 0.
        if (col != '0) begin
          col_next  = col - 6'd1;
          addr_next = addr - AW'(1);
        end
      end
      CUR_HOME: begin
        col_next  = '0;
        row_next  = '0;
        addr_next = '0;
      end
      default: ;
    endcase
  end

  // Cursor registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else begin
      col  <= col_next;
      row  <= row_next;
      addr <= addr_next;
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Character-stream front end for the text-mode video block: clears VRAM
// after reset or form feed, then writes printable characters at the cursor
// and interprets LF, CR, BS and FF. All outputs are registered.
module text_console_writer
  import text_console_writer_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  text_console_writer_if.slave bus,
  output logic [5:0]           cur_col_o,
  output logic [5:0]           cur_row_o,
  output logic                 busy_o,
  output state_t               state_o
);

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt, clr_cnt_next;
  cursor_cmd_t   cur_cmd;
  logic [AW-1:0] cur_addr;

  logic          we_q, we_next;
  logic [AW-1:0] addr_q, addr_next;
  logic [15:0]   data_q, data_next;
  logic          ready_q, ready_next;
  logic          busy_q, busy_next;

  logic          accept;

  // ready_q is only ever high in IDLE, so it alone qualifies the transfer.
  assign accept = bus.ch_valid_i && ready_q;

  // Next state, clear counter, cursor command and registered outputs.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    cur_cmd      = CUR_NONE;
    we_next      = 1'b0;
    addr_next    = addr_q;
    data_next    = data_q;
    ready_next   = 1'b0;
    busy_next    = 1'b1;
    case (state)
      ST_CLEAR: begin
        we_next   = 1'b1;
        addr_next = clr_cnt;
        data_next = {CLR_ATTR, CLR_CHAR};
        if (clr_cnt == LAST_ADDR) begin
          // Ready rises one cycle after this last write, on the first
          // IDLE edge.
          state_next   = ST_IDLE;
          clr_cnt_next = '0;
          cur_cmd      = CUR_HOME;
        end else begin
          clr_cnt_next = clr_cnt + AW'(1);
        end
      end
      ST_IDLE: begin
        ready_next = 1'b1;
        busy_next  = 1'b0;
        if (accept) begin
          if (is_printable(bus.ch_data_i)) begin
            we_next   = 1'b1;
            addr_next = cur_addr;
            data_next = {bus.ch_attr_i, bus.ch_data_i};
            cur_cmd   = CUR_ADV;
          end else begin
            case (bus.ch_data_i)
              CC_LF: cur_cmd = CUR_LF;
              CC_CR: cur_cmd = CUR_CR;
              CC_BS: cur_cmd = CUR_BS;
              CC_FF: begin
                state_next   = ST_CLEAR;
                clr_cnt_next = '0;
                cur_cmd      = CUR_HOME;
                ready_next   = 1'b0;
                busy_next    = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      default: begin
        state_next   = ST_CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  // State, clear counter and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      we_q    <= we_next;
      addr_q  <= addr_next;
      data_q  <= data_next;
      ready_q <= ready_next;
      busy_q  <= busy_next;
    end
  end

  text_console_writer_cursor u_cursor (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .cmd    (cur_cmd),
    .col    (cur_col_o),
    .row    (cur_row_o),
    .addr   (cur_addr)
  );

  assign bus.ch_ready_o  = ready_q;
  assign bus.vram_we_o   = we_q;
  assign bus.vram_addr_o = addr_q;
  assign bus.vram_data_o = data_q;
  assign busy_o          = busy_q;
  assign state_o         = state;

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer: a cell-grid reference model predicts
// every VRAM write and the cursor; a negedge monitor checks writes in order.
module tb_text_console_writer;

  localparam int T_COLS  = 60;
  localparam int T_ROWS  = 34;
  localparam int T_CELLS = T_COLS * T_ROWS;
  localparam int T_AW    = 11;
  localparam int W       = T_AW + 16;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  text_console_writer_if bus_if ();
  logic [5:0] cur_col;
  logic [5:0] cur_row;
  logic       busy;
  text_console_writer_pkg::state_t dbg_state;

  text_console_writer dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .bus       (bus_if),
    .cur_col_o (cur_col),
    .cur_row_o (cur_row),
    .busy_o    (busy),
    .state_o   (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int m_col = 0;
  int m_row = 0;

  function automatic void model_clear();
    for (int i = 0; i < T_CELLS; i++) exp_q.push_back({11'(i), 16'h0720});
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic void model_accept(input logic [7:0] c, input logic [7:0] a);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back({11'(m_row * T_COLS + m_col), a, c});
      m_col = m_col + 1;
      if (m_col == T_COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % T_ROWS;
      end
    end else if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % T_ROWS;
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) m_col = m_col - 1;
    end else if (c == 8'h0C) begin
      model_clear();
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    if (rstn && bus_if.vram_we_o === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL vram_write: got unexpected write addr=%0d data=%h, expected no write",
                 bus_if.vram_addr_o, bus_if.vram_data_o);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus_if.vram_addr_o, bus_if.vram_data_o} !== exp_w) begin
          n_fail++;
          $display("FAIL vram_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus_if.vram_addr_o, bus_if.vram_data_o, exp_w[W-1:16], exp_w[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int n = 0;
    bus_if.ch_valid_i = 1'b1;
    bus_if.ch_data_i  = c;
    bus_if.ch_attr_i  = a;
    while (bus_if.ch_ready_o !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.ch_ready_o !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got ch_ready_o=%b, expected 1 within 3000 cycles",
               bus_if.ch_ready_o);
    end else begin
      model_accept(c, a);
    end
    @(negedge clk);
    bus_if.ch_valid_i = 1'b0;
    bus_if.ch_data_i  = 8'($urandom);
    bus_if.ch_attr_i  = 8'($urandom);
    if (c != 8'h0C) begin
      n_tests++;
      if (cur_col !== 6'(m_col) || cur_row !== 6'(m_row) || bus_if.ch_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL cursor_after_%h: got col=%0d row=%0d ready=%b, expected col=%0d row=%0d ready=1",
                 c, cur_col, cur_row, bus_if.ch_ready_o, m_col, m_row);
      end
    end
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(8'h20, 8'h7E));
  endfunction

  task automatic goto(input int tc, input int tr);
    while (m_row != tr) send(8'h0A, 8'h00);
    if (m_col > tc) send(8'h0D, 8'h00);
    while (m_col < tc) send(rand_print(), 8'($urandom));
  endtask

  // Waits out a full clear starting at a negedge; 'already' counts clear
  // writes the caller has observed.
  task automatic wait_clear(input int already);
    int writes = already;
    bit done = 0;
    bit busy_ok = 1;
    bit prev_last = 0;
    bit last_before = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus_if.ch_ready_o === 1'b1) begin
        done = 1;
        last_before = prev_last;
        break;
      end
      if (busy !== 1'b1) busy_ok = 0;
      prev_last = (bus_if.vram_we_o === 1'b1 && bus_if.vram_addr_o === 11'(T_CELLS - 1));
      if (bus_if.vram_we_o === 1'b1) writes++;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL clear_timeout: got ch_ready_o=%b, expected 1 within 3000 cycles", bus_if.ch_ready_o);
    end
    n_tests++;
    if (writes != T_CELLS) begin
      n_fail++;
      $display("FAIL clear_count: got %0d writes, expected %0d", writes, T_CELLS);
    end
    n_tests++;
    if (!last_before) begin
      n_fail++;
      $display("FAIL clear_ready_timing: got last-address write before ready=%b, expected 1", last_before);
    end
    n_tests++;
    if (!busy_ok || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_busy: got busy_during_ok=%b busy_after=%b, expected 1 and 0", busy_ok, busy);
    end
    n_tests++;
    if (cur_col !== 6'd0 || cur_row !== 6'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clear_end: got col=%0d row=%0d pending=%0d, expected 0 0 0",
               cur_col, cur_row, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    bus_if.ch_valid_i = 1'b0;
    bus_if.ch_data_i  = 8'h00;
    bus_if.ch_attr_i  = 8'h00;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus_if.vram_we_o !== 1'b0 || bus_if.vram_addr_o !== 11'd0 || bus_if.vram_data_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_vram: got we=%b addr=%0d data=%h, expected 0 0 0000",
               bus_if.vram_we_o, bus_if.vram_addr_o, bus_if.vram_data_o);
    end
    n_tests++;
    if (cur_col !== 6'd0 || cur_row !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_cursor: got col=%0d row=%0d, expected 0 0", cur_col, cur_row);
    end
    n_tests++;
    if (bus_if.ch_ready_o !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: got ready=%b busy=%b, expected 0 1", bus_if.ch_ready_o, busy);
    end
    model_clear();
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_if.vram_we_o !== 1'b1 || bus_if.vram_addr_o !== 11'd0) begin
      n_fail++;
      $display("FAIL first_clear_write: got we=%b addr=%0d, expected 1 0",
               bus_if.vram_we_o, bus_if.vram_addr_o);
    end
    wait_clear(1);
  endtask

  task automatic test_back_to_back();
    send(8'h41, 8'h1E);
    n_tests++;
    if (bus_if.vram_we_o !== 1'b1 || bus_if.vram_addr_o !== 11'd0 || bus_if.vram_data_o !== 16'h1E41) begin
      n_fail++;
      $display("FAIL b2b_first: got we=%b addr=%0d data=%h, expected 1 0 1e41",
               bus_if.vram_we_o, bus_if.vram_addr_o, bus_if.vram_data_o);
    end
    send(8'h42, 8'h4F);
    n_tests++;
    if (bus_if.vram_we_o !== 1'b1 || bus_if.vram_addr_o !== 11'd1 || bus_if.vram_data_o !== 16'h4F42) begin
      n_fail++;
      $display("FAIL b2b_second: got we=%b addr=%0d data=%h, expected 1 1 4f42",
               bus_if.vram_we_o, bus_if.vram_addr_o, bus_if.vram_data_o);
    end
    n_tests++;
    if (cur_col !== 6'd2 || cur_row !== 6'd0) begin
      n_fail++;
      $display("FAIL b2b_cursor: got col=%0d row=%0d, expected 2 0", cur_col, cur_row);
    end
    @(negedge clk);
    n_tests++;
    if (bus_if.vram_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_single_pulse: got we=%b, expected 0", bus_if.vram_we_o);
    end
  endtask

  task automatic test_controls();
    goto(10, 3);
    send(8'h0D, 8'h00);
    n_tests++;
    if (cur_col !== 6'd0 || cur_row !== 6'd3 || bus_if.vram_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL cr: got col=%0d row=%0d we=%b, expected 0 3 0", cur_col, cur_row, bus_if.vram_we_o);
    end
    send(8'h08, 8'h00);
    n_tests++;
    if (cur_col !== 6'd0 || cur_row !== 6'd3 || bus_if.vram_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bs_col0: got col=%0d row=%0d we=%b, expected 0 3 0", cur_col, cur_row, bus_if.vram_we_o);
    end
    goto(7, 3);
    send(8'h08, 8'h00);
    n_tests++;
    if (cur_col !== 6'd6 || cur_row !== 6'd3 || bus_if.vram_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bs: got col=%0d row=%0d we=%b, expected 6 3 0", cur_col, cur_row, bus_if.vram_we_o);
    end
    send(8'h78, 8'h2A);
    n_tests++;
    if (bus_if.vram_we_o !== 1'b1 || bus_if.vram_addr_o !== 11'd186 || bus_if.vram_data_o !== 16'h2A78) begin
      n_fail++;
      $display("FAIL after_bs_write: got we=%b addr=%0d data=%h, expected 1 186 2a78",
               bus_if.vram_we_o, bus_if.vram_addr_o, bus_if.vram_data_o);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] a;
    a = 8'($urandom);
    goto(59, 33);
    send(8'h5A, a);
    n_tests++;
    if (bus_if.vram_we_o !== 1'b1 || bus_if.vram_addr_o !== 11'd2039 || bus_if.vram_data_o !== {a, 8'h5A}) begin
      n_fail++;
      $display("FAIL wrap_write: got we=%b addr=%0d data=%h, expected 1 2039 %h",
               bus_if.vram_we_o, bus_if.vram_addr_o, bus_if.vram_data_o, {a, 8'h5A});
    end
    n_tests++;
    if (cur_col !== 6'd0 || cur_row !== 6'd0) begin
      n_fail++;
      $display("FAIL wrap_cursor: got col=%0d row=%0d, expected 0 0", cur_col, cur_row);
    end
    goto(5, 33);
    send(8'h0A, 8'h00);
    n_tests++;
    if (cur_col !== 6'd0 || cur_row !== 6'd0 || bus_if.vram_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lf_wrap: got col=%0d row=%0d we=%b, expected 0 0 0", cur_col, cur_row, bus_if.vram_we_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] others[7] = '{8'h00, 8'h01, 8'h09, 8'h1B, 8'h7F, 8'h80, 8'hFF};
    logic [7:0] c;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: c = rand_print();
        6:       c = 8'h0A;
        7:       c = 8'h0D;
        8:       c = 8'h08;
        default: c = others[$urandom_range(0, 6)];
      endcase
      send(c, 8'($urandom));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
  endtask

  task automatic test_ff();
    goto(20, 5);
    send(8'h0C, 8'h00);
    // Keep the next character offered throughout the clear.
    bus_if.ch_valid_i = 1'b1;
    bus_if.ch_data_i  = 8'h51;
    bus_if.ch_attr_i  = 8'h3C;
    n_tests++;
    if (bus_if.ch_ready_o !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ff_ready_drop: got ready=%b busy=%b, expected 0 1", bus_if.ch_ready_o, busy);
    end
    wait_clear(0);
    send(8'h51, 8'h3C);
    n_tests++;
    if (bus_if.vram_we_o !== 1'b1 || bus_if.vram_addr_o !== 11'd0 || bus_if.vram_data_o !== 16'h3C51) begin
      n_fail++;
      $display("FAIL ff_next_char: got we=%b addr=%0d data=%h, expected 1 0 3c51",
               bus_if.vram_we_o, bus_if.vram_addr_o, bus_if.vram_data_o);
    end
  endtask

  task automatic test_reset_mid_clear();
    int seen = 0;
    send(8'h0C, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus_if.vram_we_o === 1'b1) seen++;
      if (seen == 1000) break;
    end
    n_tests++;
    if (seen != 1000) begin
      n_fail++;
      $display("FAIL midclear_reach: got %0d writes, expected 1000", seen);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if (bus_if.vram_we_o !== 1'b0 || bus_if.vram_addr_o !== 11'd0 || bus_if.vram_data_o !== 16'h0000 ||
        bus_if.ch_ready_o !== 1'b0 || busy !== 1'b1 || cur_col !== 6'd0 || cur_row !== 6'd0) begin
      n_fail++;
      $display("FAIL midclear_reset: got we=%b addr=%0d data=%h ready=%b busy=%b col=%0d row=%0d, expected 0 0 0000 0 1 0 0",
               bus_if.vram_we_o, bus_if.vram_addr_o, bus_if.vram_data_o, bus_if.ch_ready_o, busy, cur_col, cur_row);
    end
    exp_q.delete();
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_if.vram_we_o !== 1'b1 || bus_if.vram_addr_o !== 11'd0) begin
      n_fail++;
      $display("FAIL midclear_restart: got we=%b addr=%0d, expected 1 0",
               bus_if.vram_we_o, bus_if.vram_addr_o);
    end
    wait_clear(1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_controls();
    test_wrap();
    test_random();
    test_ff();
    test_reset_mid_clear();
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d pending writes, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion by 600000 time units, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream front end for the 480x272 text-mode video block. Accepts 8-bit character codes over a valid/ready handshake, interprets a small set of control codes, tracks a cursor over the 60x34 cell grid and issues single-cycle writes of {attribute, character} words into the video block's VRAM write port. Sits directly upstream of `video`, replacing ad-hoc VRAM fill logic in `top`. Runs in the VRAM write clock domain.

## Interface
- COLS, 60, text columns (480/8)
- ROWS, 34, text rows (272/8)
- AW, 11, VRAM address width; must satisfy COLS*ROWS <= 2**AW
- CLR_ATTR, 8'h07, attribute used for clear fills (light grey on black)

- clk_i  in  1  VRAM write clock (LCD_CLK in `top`)
- rstn_i  in  1  asynchronous, active-low reset
- ch_valid_i  in  1  character present
- ch_ready_o  out  1  block can accept a character this cycle
- ch_data_i  in  8  character code
- ch_attr_i  in  8  attribute {bg[3:0], fg[3:0]}, sampled with ch_data_i
- vram_we_o  out  1  active-high write strobe, one cycle per word
- vram_addr_o  out  AW  cell address = row*COLS + col
- vram_data_o  out  16  {attr[7:0], char[7:0]}
- cur_col_o  out  6  cursor column
- cur_row_o  out  6  cursor row
- busy_o  out  1  clear in progress

## Operation
- States: CLEAR, IDLE.
- CLEAR: writes {CLR_ATTR, 8'h20} to addresses 0..COLS*ROWS-1, one per cycle, ascending; ch_ready_o=0, busy_o=1. After the last address: cursor (0,0), go IDLE.
- IDLE: ch_ready_o=1, busy_o=0. Transfer when ch_valid_i & ch_ready_o.
- Accepted code handling:
  - 0x20..0x7E: write {ch_attr_i, code} at cursor; col+1; if col was COLS-1 then col=0, row+1; if row was ROWS-1 then row=0 (wrap to top, no scroll).
  - 0x0A LF: col=0, row+1 (same row wrap). No write.
  - 0x0D CR: col=0. No write.
  - 0x08 BS: if col>0, col-1; at col 0 no change. No write (does not erase).
  - 0x0C FF: go CLEAR (full clear, cursor then (0,0)).
  - All other codes: consumed, no effect.
- A linear address register is maintained incrementally alongside (row,col) (no multiplier): +1 on advance, -col on CR, +COLS-col on LF, -1 on BS, wrap to 0 past COLS*ROWS-1. Invariant addr == row*COLS+col holds at all times.
- Reset values: vram_we_o=0, vram_addr_o=0, vram_data_o=0, cur_col_o=0, cur_row_o=0, ch_ready_o=0, busy_o=1; state=CLEAR with clear counter 0.

## Timing
- All outputs registered.
- Write latency: transfer at edge N -> vram_we_o=1 with addr/data valid during cycle after edge N, exactly one cycle. Cursor outputs update at edge N.
- Throughput: one printable character per cycle, back-to-back, no bubbles.
- FF accepted at edge N: ch_ready_o=0 from edge N; first clear write (addr 0) during cycle after edge N+1 or earlier; full clear is exactly COLS*ROWS write cycles; ch_ready_o returns 1 the cycle after the last write.
- Post-reset: first clear write one cycle after rstn_i deasserts.
- Reset mid-clear or mid-stream: immediate return to reset values; clear restarts from address 0.
- ch_data_i/ch_attr_i ignored when no transfer.

## Structure
- Shared package `video_pkg`: COLS, ROWS, AW, control-code constants (CC_LF, CC_CR, CC_BS, CC_FF), default attribute, CGA colour indices; also used by `video`.
- Single module, no sub-modules; the cursor/address tracker may be split out as `text_cursor` if it exceeds ~100 lines.

## Test plan
- Reset release -> 2040 consecutive writes, addr 0..2039, data 16'h0720, busy_o high throughout, then ch_ready_o=1, cursor (0,0).
- After clear, send 'A' attr 8'h1E then 'B' attr 8'h4F back-to-back -> writes addr 0 data 16'h1E41, addr 1 data 16'h4F42 on consecutive cycles; cursor (2,0).
- Cursor at (59,33), send 'Z' -> write addr 2039 data {attr,8'h5A}; cursor (0,0). Then LF at (5,33) -> cursor (0,0), no write.
- At (10,3): CR -> (0,3); BS at (0,3) -> (0,3); BS at (7,3) -> (6,3); none produce writes; next 'x' writes addr 186.
- FF at (20,5) with ch_valid_i held high -> ready drops, 2040 clear writes, next char written at addr 0.
- Assert rstn_i at clear count 1000 -> outputs to reset values immediately; after release clear restarts at addr 0.
